de2_70_ethernet_nios2_qsys_0_ocimem_arbiter: RTL and testbench

- **Function:** Shares the Nios II on-chip debug memory (OCI RAM) single port between two requesters.
  - JTAG debug requester: single-cycle command pulses in the system-clock domain, with an auto-incrementing address pointer.
  - Avalon-MM debug slave requester: waitrequest flow control.
- **Placement:** Sits between the debug module's system-clock side and the OCI RAM.
- **Arbitration:** Round-robin on ties; each requester has one outstanding access.

---
 rtl/de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv | 155 +++++++++++++++
 tb/tb_de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv
// rtl/de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv - OCI RAM port arbiter between JTAG debug commands and an Avalon-MM debug slave
module de2_70_ethernet_nios2_qsys_0_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr_in,
    input  logic              jtag_read,
    input  logic              jtag_write,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              jtag_clr_overrun,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT_J,
        S_GNT_A,
        S_RD_J,
        S_RD_A
    } state_t;

    state_t            state, state_nxt;
    logic              last_grant_av, last_grant_av_nxt;
    logic              grant_j, grant_a;
    logic              av_req;
    logic              jtag_done_nxt;

    logic              pend_valid;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic [ADDR_W-1:0] ptr;

    logic              jtag_cmd;
    logic              cmd_accept;
    logic              cmd_drop;
    logic [ADDR_W-1:0] cmd_addr;

    assign av_req     = av_read | av_write;
    assign jtag_cmd   = jtag_read | jtag_write;
    // pend_valid stays set through GNT_J/RD_J, so it alone marks the entry as full
    assign cmd_accept = jtag_cmd & ~pend_valid;
    assign cmd_drop   = jtag_cmd & pend_valid;
    assign cmd_addr   = jtag_addr_load ? jtag_addr_in : ptr;

    always_comb begin
        state_nxt         = state;
        last_grant_av_nxt = last_grant_av;
        grant_j           = 1'b0;
        grant_a           = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_valid && (!av_req || last_grant_av)) begin
                    grant_j           = 1'b1;
                    state_nxt         = S_GNT_J;
                    last_grant_av_nxt = 1'b0;
                end else if (av_req) begin
                    grant_a           = 1'b1;
                    state_nxt         = S_GNT_A;
                    last_grant_av_nxt = 1'b1;
                end
            end
            S_GNT_J: state_nxt = mem_wr ? S_IDLE : S_RD_J;
            S_GNT_A: state_nxt = mem_wr ? S_IDLE : S_RD_A;
            S_RD_J:  state_nxt = S_IDLE;
            S_RD_A:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign jtag_done_nxt = ((state == S_GNT_J) && mem_wr) || (state == S_RD_J);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            last_grant_av <= 1'b1;
            mem_en        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            jtag_done     <= 1'b0;
            jtag_rdata    <= '0;
            jtag_overrun  <= 1'b0;
            pend_valid    <= 1'b0;
            pend_wr       <= 1'b0;
            pend_addr     <= '0;
            pend_wdata    <= '0;
            ptr           <= '0;
        end else begin
            state         <= state_nxt;
            last_grant_av <= last_grant_av_nxt;
            mem_en        <= grant_j | grant_a;
            if (grant_j) begin
                mem_wr    <= pend_wr;
                mem_addr  <= pend_addr;
                mem_wdata <= pend_wdata;
            end else if (grant_a) begin
                mem_wr    <= av_write;
                mem_addr  <= av_address;
                mem_wdata <= av_writedata;
            end

            jtag_done <= jtag_done_nxt;
            if (state == S_RD_J) begin
                jtag_rdata <= mem_rdata;
            end

            if (jtag_done_nxt) begin
                pend_valid <= 1'b0;
            end else if (cmd_accept) begin
                pend_valid <= 1'b1;
                pend_wr    <= jtag_write;
                pend_addr  <= cmd_addr;
                pend_wdata <= jtag_wdata;
            end

            if (cmd_accept) begin
                ptr <= cmd_addr + ADDR_W'(1);
            end else if (jtag_addr_load) begin
                ptr <= jtag_addr_in;
            end

            // a new drop outranks a simultaneous clear
            if (cmd_drop) begin
                jtag_overrun <= 1'b1;
            end else if (jtag_clr_overrun) begin
                jtag_overrun <= 1'b0;
            end
        end
    end

    assign jtag_addr      = ptr;
    assign jtag_busy      = pend_valid || (state == S_GNT_J) || (state == S_RD_J);
    assign av_waitrequest = !reset_n || !(((state == S_GNT_A) && mem_wr) || (state == S_RD_A));
    assign av_readdata    = (state == S_RD_A) ? mem_rdata : '0;

endmodule

// File: tb/tb_de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv
// tb/tb_de2_70_ethernet_nios2_qsys_0_ocimem_arbiter.sv - self-checking bench for the OCI RAM arbiter
module tb_de2_70_ethernet_nios2_qsys_0_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        jtag_addr_load;
    logic [7:0]  jtag_addr_in;
    logic        jtag_read;
    logic        jtag_write;
    logic [31:0] jtag_wdata;
    logic        jtag_clr_overrun;
    logic [7:0]  jtag_addr;
    logic [31:0] jtag_rdata;
    logic        jtag_done;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        mem_en;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    de2_70_ethernet_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_addr_load(jtag_addr_load), .jtag_addr_in(jtag_addr_in),
        .jtag_read(jtag_read), .jtag_write(jtag_write), .jtag_wdata(jtag_wdata),
        .jtag_clr_overrun(jtag_clr_overrun), .jtag_addr(jtag_addr),
        .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_busy(jtag_busy),
        .jtag_overrun(jtag_overrun), .av_address(av_address), .av_read(av_read),
        .av_write(av_write), .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h3C, 8'hA5};
    endfunction

    // single-port RAM with one-cycle registered read
    logic [31:0] ram [0:255];
    logic        init_en;
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
        end else if (mem_en) begin
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    logic [40:0] gq[$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (mem_en)    gq.push_back({mem_wr, mem_addr, mem_wdata});
        if (jtag_done) done_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_issue(input logic ld, input logic [7:0] la, input logic rd,
                              input logic wr, input logic [31:0] wd);
        jtag_addr_load = ld; jtag_addr_in = la; jtag_read = rd; jtag_write = wr; jtag_wdata = wd;
        tick();
        jtag_addr_load = 1'b0; jtag_read = 1'b0; jtag_write = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            if (jtag_done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic av_access(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd);
        av_write = wr; av_read = ~wr; av_address = a; av_writedata = wd;
        lat = -1; rd = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!av_waitrequest) begin
                lat = c;
                rd  = av_readdata;
                break;
            end
        end
        av_write = 1'b0; av_read = 1'b0;
    endtask

    logic [31:0] sh [0:255];
    int          lat, g0, d0, wcnt;
    logic [31:0] rdv;

    initial begin
        for (int i = 0; i < 256; i++) sh[i] = init_word(8'(i));
        reset_n = 1'b0; init_en = 1'b1;
        jtag_addr_load = 0; jtag_addr_in = 0; jtag_read = 0; jtag_write = 0;
        jtag_wdata = 0; jtag_clr_overrun = 0;
        av_address = 8'h10; av_read = 1'b1; av_write = 0; av_writedata = 0;

        // reset defaults with a read held on the Avalon side
        tick(); init_en = 1'b0; tick();
        check("rst_waitreq", av_waitrequest, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_jtag_addr", jtag_addr, 0);
        check("rst_overrun", jtag_overrun, 0);
        check("rst_done", jtag_done, 0);
        check("rst_busy", jtag_busy, 0);
        check("rst_readdata", av_readdata, 0);
        reset_n = 1'b1;
        tick();
        check("av_rd_c1_wait", av_waitrequest, 1);
        tick();
        check("av_rd_c2_wait", av_waitrequest, 0);
        check("av_rd_c2_data", av_readdata, 32'hDEADBEEF);
        av_read = 1'b0;
        tick();
        check("av_rd_c3_wait", av_waitrequest, 1);

        // Avalon write then read back
        av_access(1'b1, 8'h70, 32'h13579BDF, lat, rdv);
        check("av_wr_lat", lat, 1);
        tick();
        av_access(1'b0, 8'h70, 32'h0, lat, rdv);
        check("av_rd_lat", lat, 2);
        check("av_rd_back", rdv, 32'h13579BDF);
        tick();

        // auto-increment and wrap
        jtag_issue(1'b1, 8'hFE, 1'b0, 1'b0, 32'h0);
        check("ld_ptr", jtag_addr, 8'hFE);
        g0 = gq.size();
        jtag_issue(1'b0, 8'h00, 1'b0, 1'b1, 32'h11111111);
        check("busy_pending", jtag_busy, 1);
        wait_done(lat);
        check("jwr1_lat", lat, 3);
        check("jwr1_mem", gq[g0], {1'b1, 8'hFE, 32'h11111111});
        jtag_issue(1'b0, 8'h00, 1'b0, 1'b1, 32'h22222222);
        wait_done(lat);
        check("jwr2_lat", lat, 3);
        check("jwr2_mem", gq[g0+1], {1'b1, 8'hFF, 32'h22222222});
        check("wrap_ptr", jtag_addr, 8'h00);
        jtag_issue(1'b1, 8'hFE, 1'b0, 1'b0, 32'h0);
        jtag_issue(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        wait_done(lat);
        check("jrd_lat", lat, 4);
        check("jrd_data", jtag_rdata, 32'h11111111);
        check("jrd_ptr", jtag_addr, 8'hFF);
        tick();
        check("busy_clear", jtag_busy, 0);

        // first tie after reset goes to JTAG
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
        g0 = gq.size(); d0 = done_cnt;
        jtag_issue(1'b1, 8'h48, 1'b0, 1'b1, 32'hCAFE0001);
        av_write = 1'b1; av_address = 8'h70; av_writedata = 32'hBEEF0002;
        wcnt = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!av_waitrequest) begin wcnt = c; break; end
        end
        av_write = 1'b0;
        tick(); tick();
        check("tie1_av_wait", wcnt, 3);
        check("tie1_grants", gq.size() - g0, 2);
        check("tie1_first", gq[g0][39:32], 8'h48);
        check("tie1_second", gq[g0+1][39:32], 8'h70);
        check("tie1_done", done_cnt - d0, 1);

        // after a JTAG-only grant, the next tie goes to Avalon
        jtag_issue(1'b1, 8'h4C, 1'b0, 1'b1, 32'h0000004C);
        wait_done(lat);
        g0 = gq.size();
        jtag_issue(1'b1, 8'h4D, 1'b0, 1'b1, 32'h0000004D);
        av_write = 1'b1; av_address = 8'h71; av_writedata = 32'hBEEF0003;
        wcnt = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!av_waitrequest) begin wcnt = c; break; end
        end
        av_write = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("tie2_av_wait", wcnt, 1);
        check("tie2_first", gq[g0][39:32], 8'h71);
        check("tie2_second", gq[g0+1][39:32], 8'h4D);

        // overrun: second command while the first is pending
        jtag_issue(1'b1, 8'h50, 1'b0, 1'b0, 32'h0);
        d0 = done_cnt;
        jtag_issue(1'b0, 8'h00, 1'b0, 1'b1, 32'h0F0F0F0F);
        jtag_issue(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        check("ovr_set", jtag_overrun, 1);
        check("ovr_ptr", jtag_addr, 8'h51);
        for (int i = 0; i < 5; i++) tick();
        check("ovr_one_done", done_cnt - d0, 1);
        jtag_clr_overrun = 1'b1; tick(); jtag_clr_overrun = 1'b0;
        check("ovr_clr", jtag_overrun, 0);
        jtag_issue(1'b0, 8'h00, 1'b0, 1'b1, 32'h0F0F0F10);
        jtag_clr_overrun = 1'b1;
        jtag_issue(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        jtag_clr_overrun = 1'b0;
        check("ovr_set_wins", jtag_overrun, 1);
        check("ovr_ptr2", jtag_addr, 8'h52);
        for (int i = 0; i < 5; i++) tick();
        jtag_clr_overrun = 1'b1; tick(); jtag_clr_overrun = 1'b0;

        // load together with a write
        g0 = gq.size();
        jtag_issue(1'b1, 8'h40, 1'b0, 1'b1, 32'hA5A5A5A5);
        check("ldcmd_ptr", jtag_addr, 8'h41);
        wait_done(lat);
        check("ldcmd_lat", lat, 3);
        check("ldcmd_mem", gq[g0], {1'b1, 8'h40, 32'hA5A5A5A5});

        // reset in GNT_J aborts the access
        jtag_issue(1'b1, 8'h60, 1'b0, 1'b0, 32'h0);
        d0 = done_cnt;
        jtag_issue(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_busy", jtag_busy, 0);
        check("abort_ptr", jtag_addr, 8'h00);

        // random concurrent traffic on disjoint address regions
        fork
            begin : jtag_side
                logic [7:0]  ptr_m, la, a;
                logic [31:0] wd, exp_d;
                int          mode, jl;
                bit          w;
                ptr_m = 8'h00;
                for (int n = 0; n < 16; n++) begin
                    mode = (n == 0) ? 1 : $urandom_range(0, 2);
                    la   = 8'h20 + 8'($urandom_range(0, 15));
                    w    = 1'($urandom_range(0, 1));
                    wd   = $urandom;
                    if (mode == 2) begin
                        jtag_issue(1'b1, la, 1'b0, 1'b0, 32'h0);
                        ptr_m = la;
                    end
                    a     = (mode == 1) ? la : ptr_m;
                    ptr_m = a + 8'd1;
                    exp_d = sh[a];
                    if (w) sh[a] = wd;
                    jtag_issue(mode == 1, la, ~w, w, wd);
                    wait_done(jl);
                    check("rnd_j_lat", (jl > 0) && (jl <= (w ? 6 : 7)), 1);
                    if (!w) check("rnd_j_rdata", jtag_rdata, exp_d);
                    check("rnd_j_ptr", jtag_addr, ptr_m);
                    for (int g = $urandom_range(0, 3); g > 0; g--) tick();
                end
            end
            begin : av_side
                logic [7:0]  a;
                logic [31:0] wd, exp_d, rd;
                int          al;
                bit          w;
                for (int n = 0; n < 16; n++) begin
                    for (int g = $urandom_range(1, 3); g > 0; g--) tick();
                    a  = 8'h80 + 8'($urandom_range(0, 7));
                    w  = 1'($urandom_range(0, 1));
                    wd = $urandom;
                    exp_d = sh[a];
                    if (w) sh[a] = wd;
                    av_access(w, a, wd, al, rd);
                    check("rnd_a_lat", (al > 0) && (al <= (w ? 4 : 5)), 1);
                    if (!w) check("rnd_a_rdata", rd, exp_d);
                end
            end
        join
        tick(); tick();
        check("rnd_overrun", jtag_overrun, 0);
        check("rnd_busy", jtag_busy, 0);
        for (int i = 8'h20; i < 8'h40; i++) check("ram_j", ram[i], sh[i]);
        for (int i = 8'h80; i < 8'h88; i++) check("ram_a", ram[i], sh[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
